// File: rtl/audio_pkg.sv
// audio_pkg: shared I2S state encoding and frame constants for the audio path
package audio_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;
   localparam int I2S_SLOT_BITS = 32;
   localparam int I2S_FRAME_BITS = 64;
   localparam int DEFAULT_DATA_WIDTH = 32;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with combinational head and occupancy output
module sample_fifo #(
   parameter int WIDTH = 24,
   parameter int AW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] mem [2**AW];
   logic [AW:0] wr, rd;
   logic do_push, do_pop;
   assign level = wr - rd;
   assign full = level == (AW+1)'(2**AW);
   assign empty = wr == rd;
   assign do_pop = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign head = mem[rd[AW-1:0]];
   // storage write; contents need no reset since the pointers gate every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr[AW-1:0]] <= din;
   end
   // read/write pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr <= '0;
         rd <= '0;
      end else begin
         wr <= wr + (AW+1)'(do_push);
         rd <= rd + (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers mono samples and sends each as a Philips I2S stereo frame
module i2s_tx_serializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int OUT_WIDTH = 24,
   parameter int BCLK_HALF = 16,
   parameter int FIFO_AW = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] audio_in,
   input  logic                  enable,
   input  logic                  clear_flags,
   output logic                  i2s_bclk,
   output logic                  i2s_lrclk,
   output logic                  i2s_sdata,
   output logic [FIFO_AW:0]      fifo_level,
   output logic                  underflow,
   output logic                  overflow
);
   localparam int DIV_W = $clog2(BCLK_HALF);
   localparam logic [DIV_W-1:0] DIV_END = DIV_W'(BCLK_HALF - 1);
   localparam logic [5:0] LAST_BIT = 6'(I2S_FRAME_BITS - 1);
   i2s_state_t state, state_next;
   logic [DIV_W-1:0] div;
   logic [5:0] bit_cnt, bit_next;
   logic [OUT_WIDTH-1:0] frame, head;
   logic [31:0] slot_word;
   logic tick, fall, pop, full, empty, drop, unused_lsbs;
   assign tick = state != IDLE && div == DIV_END;
   assign fall = tick && i2s_bclk;
   assign bit_next = bit_cnt + 6'd1;
   assign pop = fall && bit_next == LAST_BIT;
   assign drop = sample_valid && full && !pop;
   // left-justify the word in a slot so bits past OUT_WIDTH read as zero padding
   assign slot_word = 32'(frame) << (I2S_SLOT_BITS - OUT_WIDTH);
   assign unused_lsbs = ^audio_in;
   sample_fifo #(.WIDTH(OUT_WIDTH), .AW(FIFO_AW)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(sample_valid),
      .pop(pop),
      .din(audio_in[DATA_WIDTH-1 -: OUT_WIDTH]),
      .head(head),
      .full(full),
      .empty(empty),
      .level(fifo_level)
   );
   // state register
   always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_next;
   end
   // DRAIN finishes the current frame and parks at its last bit unless re-enabled
   always_comb begin
      state_next = state == IDLE ? (enable ? RUN : IDLE)
                 : state == RUN  ? (enable ? RUN : DRAIN)
                 : enable ? RUN : pop ? IDLE : DRAIN;
   end
   // divider, bit counter and serial outputs; IDLE holds them at the frame-end position
   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         div <= '0;
         i2s_bclk <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
         bit_cnt <= LAST_BIT;
      end else begin
         div <= tick ? '0 : div + 1'b1;
         i2s_bclk <= i2s_bclk ^ tick;
         if (fall) begin
            bit_cnt <= bit_next;
            i2s_lrclk <= bit_next >= 6'd31 && bit_next != LAST_BIT;
            i2s_sdata <= slot_word[5'd31 - bit_next[4:0]];
         end
      end
   end
   // frame register loads at the last bit of each frame; flags are sticky, new errors win over clear
   always_ff @(posedge clk) begin
      if (reset) begin
         frame <= '0;
         underflow <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (pop) frame <= empty ? '0 : head;
         underflow <= (underflow && !clear_flags) || (pop && empty);
         overflow <= (overflow && !clear_flags) || drop;
      end
   end
endmodule
